// File: rtl/msg_out_queue.sv
// rtl/msg_out_queue.sv - register FIFO between the message controller and an AXI-Stream-style consumer
module msg_out_queue #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DEPTH         = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
  input  logic                       msg_valid,
  input  logic                       msg_error,
  output logic [8*MAX_MSG_BYTES-1:0] m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic [CNT_WIDTH-1:0]       err_count,
  input  logic                       clr_counts
);

  localparam int DW = 8 * MAX_MSG_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]        DEPTH_L = LW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;

  logic pop;
  logic accept;
  logic push;
  logic drop;

  assign m_tvalid = (count != '0);
  assign full     = (count == DEPTH_L);
  assign level    = count;
  assign m_tdata  = mem[rd_ptr];

  // An error pulse vetoes any message presented in the same cycle.
  assign accept = msg_valid && !msg_error;
  assign pop    = m_tvalid && m_tready;
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= msg_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + LW'(1);
      end else if (pop && !push) begin
        count <= count - LW'(1);
      end
    end
  end

  // Counters saturate; a clear wins over any increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      err_count  <= '0;
    end else if (clr_counts) begin
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      if (drop && drop_count != CNT_MAX) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
      if (msg_error && err_count != CNT_MAX) begin
        err_count <= err_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_msg_out_queue.sv
// tb/tb_msg_out_queue.sv - vector table, corner sequences and randomized model check for msg_out_queue
module tb_msg_out_queue;

  localparam int MB    = 32;
  localparam int DEPTH = 4;
  localparam int DW    = 8 * MB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] msg_data;
  logic          msg_valid, msg_error, m_tready, clr_counts;

  logic [DW-1:0] m_tdata;
  logic          m_tvalid, full;
  logic [2:0]    level;
  logic [15:0]   drop_count, err_count;

  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_full;
  logic [2:0]    s_level;
  logic [1:0]    s_drop, s_err;

  msg_out_queue #(.MAX_MSG_BYTES(MB), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .msg_data(msg_data), .msg_valid(msg_valid), .msg_error(msg_error),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .level(level), .full(full),
    .drop_count(drop_count), .err_count(err_count), .clr_counts(clr_counts)
  );

  msg_out_queue #(.MAX_MSG_BYTES(MB), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .msg_data(msg_data), .msg_valid(msg_valid), .msg_error(msg_error),
    .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(m_tready), .level(s_level), .full(s_full),
    .drop_count(s_drop), .err_count(s_err), .clr_counts(clr_counts)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of messages plus integer counters.
  logic [DW-1:0] mq[$];
  int mdrop, merr, merr2;

  task automatic model_reset();
    mq.delete();
    mdrop = 0;
    merr  = 0;
    merr2 = 0;
  endtask

  task automatic cycle();
    int sz;
    bit do_pop, acc;
    sz     = mq.size();
    do_pop = (sz > 0) && m_tready;
    acc    = msg_valid && !msg_error;
    if (clr_counts) begin
      mdrop = 0; merr = 0; merr2 = 0;
    end else begin
      if (msg_error) begin
        if (merr < 65535) merr++;
        if (merr2 < 3) merr2++;
      end
      if (acc && sz == DEPTH && !do_pop && mdrop < 65535) mdrop++;
    end
    if (do_pop) void'(mq.pop_front());
    if (acc && (sz < DEPTH || do_pop)) mq.push_back(msg_data);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("rnd_tvalid", DW'(m_tvalid), DW'(mq.size() != 0));
    chk("rnd_level", DW'(level), DW'(mq.size()));
    chk("rnd_full", DW'(full), DW'(mq.size() == DEPTH));
    chk("rnd_drop", DW'(drop_count), DW'(mdrop));
    chk("rnd_err", DW'(err_count), DW'(merr));
    chk("rnd_err_sat", DW'(s_err), DW'(merr2));
    if (mq.size() != 0) chk("rnd_head", m_tdata, mq[0]);
  endtask

  task automatic set_in(input bit v, input bit e, input bit rdy, input bit clr, input logic [31:0] d);
    msg_valid  = v;
    msg_error  = e;
    m_tready   = rdy;
    clr_counts = clr;
    msg_data   = DW'(d);
  endtask

  typedef struct {
    bit          v, e, rdy, clr;
    logic [31:0] d;
    bit          tv;
    int          lvl, drop, err;
    logic [31:0] head;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // v e rdy clr data | tvalid level drop err head
    tbl.push_back('{1, 0, 1, 0, 32'h11223344, 1, 1, 0, 0, 32'h11223344});
    tbl.push_back('{0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0, 32'hA0,       1, 1, 0, 0, 32'hA0});
    tbl.push_back('{1, 0, 0, 0, 32'hA1,       1, 2, 0, 0, 32'hA0});
    tbl.push_back('{1, 0, 0, 0, 32'hA2,       1, 3, 0, 0, 32'hA0});
    tbl.push_back('{1, 0, 0, 0, 32'hA3,       1, 4, 0, 0, 32'hA0});
    tbl.push_back('{1, 0, 0, 0, 32'hA4,       1, 4, 1, 0, 32'hA0});
    tbl.push_back('{1, 0, 1, 0, 32'hA5,       1, 4, 1, 0, 32'hA1});
    tbl.push_back('{0, 0, 1, 0, 32'h0,        1, 3, 1, 0, 32'hA2});
    tbl.push_back('{0, 0, 1, 0, 32'h0,        1, 2, 1, 0, 32'hA3});
    tbl.push_back('{0, 0, 1, 0, 32'h0,        1, 1, 1, 0, 32'hA5});
    tbl.push_back('{0, 0, 1, 0, 32'h0,        0, 0, 1, 0, 32'h0});
    tbl.push_back('{0, 0, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'hBB,       0, 0, 0, 1, 32'h0});
    tbl.push_back('{0, 1, 0, 0, 32'h0,        0, 0, 0, 2, 32'h0});
    tbl.push_back('{0, 1, 0, 0, 32'h0,        0, 0, 0, 3, 32'h0});
    tbl.push_back('{0, 1, 0, 0, 32'h0,        0, 0, 0, 4, 32'h0});
    tbl.push_back('{1, 0, 0, 1, 32'hCC,       1, 1, 0, 0, 32'hCC});

    rst = 1'b1;
    set_in(0, 0, 0, 0, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_tvalid", DW'(m_tvalid), DW'(0));
    chk("reset_level", DW'(level), DW'(0));
    chk("reset_full", DW'(full), DW'(0));
    chk("reset_tdata", m_tdata, DW'(0));
    chk("reset_drop", DW'(drop_count), DW'(0));
    chk("reset_err", DW'(err_count), DW'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      set_in(tbl[i].v, tbl[i].e, tbl[i].rdy, tbl[i].clr, tbl[i].d);
      cycle();
      chk($sformatf("vec%0d_tvalid", i), DW'(m_tvalid), DW'(tbl[i].tv));
      chk($sformatf("vec%0d_level", i), DW'(level), DW'(tbl[i].lvl));
      chk($sformatf("vec%0d_full", i), DW'(full), DW'(tbl[i].lvl == DEPTH));
      chk($sformatf("vec%0d_drop", i), DW'(drop_count), DW'(tbl[i].drop));
      chk($sformatf("vec%0d_err", i), DW'(err_count), DW'(tbl[i].err));
      if (tbl[i].tv) chk($sformatf("vec%0d_head", i), m_tdata, DW'(tbl[i].head));
    end

    // Saturation of a 2-bit error counter, then clear racing a pulse.
    set_in(0, 0, 0, 1, 32'h0);
    cycle();
    for (int i = 1; i <= 5; i++) begin
      set_in(0, 1, 0, 0, 32'h0);
      cycle();
      chk($sformatf("sat_err_%0d", i), DW'(s_err), DW'((i > 3) ? 3 : i));
      chk($sformatf("wide_err_%0d", i), DW'(err_count), DW'(i));
    end
    set_in(0, 1, 0, 1, 32'h0);
    cycle();
    chk("sat_err_clr", DW'(s_err), DW'(0));
    chk("wide_err_clr", DW'(err_count), DW'(0));

    // Async reset with three entries stored, checked before the next edge.
    set_in(1, 0, 0, 0, 32'hD1);
    cycle();
    set_in(1, 0, 0, 0, 32'hD2);
    cycle();
    set_in(0, 0, 0, 0, 32'h0);
    chk("pre_rst_level", DW'(level), DW'(3));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", DW'(m_tvalid), DW'(0));
    chk("arst_level", DW'(level), DW'(0));
    chk("arst_tdata", m_tdata, DW'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_in(1, 0, 0, 0, 32'hDD);
    cycle();
    chk("post_rst_tvalid", DW'(m_tvalid), DW'(1));
    chk("post_rst_head", m_tdata, DW'(32'hDD));
    chk("post_rst_level", DW'(level), DW'(1));

    // Randomized traffic, alternating light and heavy backpressure.
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct    = ((i / 400) % 2 == 1) ? 25 : 80;
      msg_valid  = ($urandom_range(0, 99) < 60);
      msg_error  = ($urandom_range(0, 9) == 0);
      m_tready   = ($urandom_range(0, 99) < rdy_pct);
      clr_counts = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < DW / 32; k++) msg_data[k*32 +: 32] = $urandom;
      cycle();
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msg_out_queue.md
# msg_out_queue

Output buffer directly downstream of the message controller. Captures each assembled message (msg_data qualified by msg_valid) into a small register FIFO and presents it on an AXI-Stream-style master port with full valid/ready backpressure. Error pulses are not stored; they are only counted. Messages arriving while the queue is full are dropped and counted.

## Interface
- MAX_MSG_BYTES, 32, message width in bytes; the data path is 8*MAX_MSG_BYTES bits.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 16, width of the drop and error counters.

Ports (reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- msg_data  in  8*MAX_MSG_BYTES  message payload from the controller.
- msg_valid  in  1  single-cycle pulse: msg_data holds a complete message.
- msg_error  in  1  single-cycle pulse: the controller discarded a message.
- m_tdata  out  8*MAX_MSG_BYTES  head-of-queue message.
- m_tvalid  out  1  queue not empty.
- m_tready  in  1  consumer accepts the head entry.
- level  out  $clog2(DEPTH)+1  number of entries stored, 0..DEPTH.
- full  out  1  level == DEPTH.
- drop_count  out  CNT_WIDTH  messages lost because the queue was full; saturating.
- err_count  out  CNT_WIDTH  msg_error pulses received; saturating.
- clr_counts  in  1  synchronous clear of both counters.

## Operation
- Storage: DEPTH × (8*MAX_MSG_BYTES) register array.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits. They wrap naturally from DEPTH-1 to 0.
- Occupancy: an explicit count register drives level, full, and m_tvalid.
- pop = m_tvalid && m_tready. Pop advances rd_ptr.
- push condition:
  - push = msg_valid && !msg_error && (!full || pop).
  - A push writes mem[wr_ptr] and advances wr_ptr.
  - Writing while full is allowed only if a pop happens in the same cycle. The freed slot is the one being written.
- Count update: push without pop gives +1; pop without push gives −1; push with pop (or neither) leaves it unchanged.
- Drop: msg_valid && !msg_error && full && !pop. Nothing is written, and drop_count increments.
- Error: a msg_error cycle increments err_count. If msg_valid is high in the same cycle, error wins: no push and no drop count.
- Counters:
  - Both saturate at 2^CNT_WIDTH−1.
  - clr_counts has priority over any increment in the same cycle; both counters become 0.
- m_tdata = mem[rd_ptr], read combinationally from the registers. It must be held stable while m_tvalid && !m_tready.
- The queue has no FSM. Its state is fully defined by (count, wr_ptr, rd_ptr). Count values 0 and DEPTH are the only boundary states:
  - Empty (count 0): m_tready is ignored and no pop occurs.
  - Full (count DEPTH): handled per the push/drop rules above.

## Timing
- Reset (asynchronous assert; release synchronous to clk): count, wr_ptr, rd_ptr, drop_count, err_count and every mem entry become 0. As a result m_tvalid=0, m_tdata=0, level=0, full=0.
- Reset asserted mid-operation discards all stored messages immediately, with no clock edge needed.
- Latency: a message pushed at edge N gives m_tvalid=1 with that data after edge N, i.e. one cycle later. There is no fall-through within the same cycle.
- Throughput: one push and one pop per cycle, sustained indefinitely at any level, including level DEPTH.
- level, full and the counters are registered and update on the edge that performs the operation.
- m_tvalid depends only on registered state. It never depends combinationally on m_tready or msg_valid.

## Test plan
- Single message, consumer ready:
  - Stimulus: after reset, msg_valid pulse with msg_data=0x…0011223344 and m_tready=1.
  - Required: the next cycle shows m_tvalid=1 and m_tdata=0x…0011223344. The cycle after shows m_tvalid=0. level goes 0→1→0.
- Fill and drop with DEPTH=4:
  - Stimulus: m_tready=0, push 5 messages D0..D4.
  - Required: full=1 and level=4 after the 4th push. The 5th push gives drop_count=1. Then m_tready=1 drains D0,D1,D2,D3 in order.
- Push and pop while full:
  - Stimulus: queue full (D0..D3), one cycle with msg_valid=1 (D4) and m_tready=1.
  - Required: D0 leaves, D4 is stored, level stays 4, drop_count is unchanged. Draining yields D1,D2,D3,D4.
- Error priority and counting:
  - Stimulus: msg_valid=1 and msg_error=1 in the same cycle, then 3 lone msg_error pulses.
  - Required: level stays 0, err_count=4, drop_count=0.
- Counter saturation and clear with CNT_WIDTH=2:
  - Stimulus: 5 error pulses, then clr_counts=1 in the same cycle as a 6th pulse.
  - Required: err_count reads 3 after the 5th pulse and 0 after the clear.
- Async reset mid-stream:
  - Stimulus: queue holds 3 entries; assert rst between clock edges.
  - Required: m_tvalid=0, level=0 and m_tdata=0 before the next edge. After release, a new push appears one cycle later as the head.
